// File: rtl/nonce_reporter.sv
// Captures miner golden nonces on each new ticket and streams them
// as four bytes over a valid/ready link, with one pending slot.
module nonce_reporter #(
  parameter logic [27:0] NONCE_ADJ = 28'd0,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        got_ticket,
  input  logic [31:0] golden_nonce,
  input  logic        start_mining,
  input  logic        clr_ovf,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        ovf,
  output logic [15:0] tickets_sent
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]  state;
  logic        got_q;
  logic [31:0] shift;
  logic [31:0] pend;
  logic        pend_full;
  logic [1:0]  idx;
  logic [1:0]  sel;
  logic [7:0]  cur_byte;
  logic [31:0] adj;
  logic        ev;
  logic        hs;
  logic        last;
  logic        drop;

  // Top nibble is the nonce_start field; only the count is corrected.
  assign adj  = {golden_nonce[31:28], golden_nonce[27:0] - NONCE_ADJ};
  assign ev   = got_ticket & ~got_q;
  assign hs   = (state == SEND) & tx_ready;
  assign last = hs & (idx == 2'd3);
  assign drop = ev & (state == SEND) & pend_full & ~last;

  assign sel = MSB_FIRST ? (2'd3 - idx) : idx;

  always_comb begin
    cur_byte = 8'h00;
    case (sel)
      2'd0:    cur_byte = shift[7:0];
      2'd1:    cur_byte = shift[15:8];
      2'd2:    cur_byte = shift[23:16];
      default: cur_byte = shift[31:24];
    endcase
  end

  assign tx_valid = (state == SEND);
  assign tx_data  = (state == SEND) ? cur_byte : 8'h00;
  assign busy     = (state == SEND) | pend_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      got_q        <= 1'b0;
      shift        <= 32'd0;
      pend         <= 32'd0;
      pend_full    <= 1'b0;
      idx          <= 2'd0;
      ovf          <= 1'b0;
      tickets_sent <= 16'd0;
    end else begin
      got_q <= start_mining ? 1'b0 : got_ticket;

      if (drop)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;

      case (state)
        IDLE: begin
          if (ev) begin
            shift <= adj;
            idx   <= 2'd0;
            state <= SEND;
          end
        end
        default: begin
          if (hs)
            idx <= idx + 2'd1;
          if (last) begin
            tickets_sent <= tickets_sent + 16'd1;
            // Pending nonce goes first; a same-cycle event refills pending.
            if (pend_full) begin
              shift     <= pend;
              pend      <= adj;
              pend_full <= ev;
            end else if (ev) begin
              shift <= adj;
            end else begin
              state <= IDLE;
            end
          end else if (ev && !pend_full) begin
            pend      <= adj;
            pend_full <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_reporter.sv
// Directed bench for nonce_reporter: default instance plus one with
// NONCE_ADJ=3 and MSB_FIRST=1.
module tb_nonce_reporter;

  logic        clk;
  logic        rst;
  logic        got_ticket;
  logic [31:0] golden_nonce;
  logic        start_mining;
  logic        clr_ovf;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        ovf;
  logic [15:0] tickets_sent;

  logic        got2;
  logic [31:0] nonce2;
  logic        start2;
  logic        clr2;
  logic [7:0]  data2;
  logic        valid2;
  logic        ready2;
  logic        busy2;
  logic        ovf2;
  logic [15:0] sent2;

  int errors = 0;
  int checks = 0;

  nonce_reporter u_dut (
    .clk          (clk),
    .rst          (rst),
    .got_ticket   (got_ticket),
    .golden_nonce (golden_nonce),
    .start_mining (start_mining),
    .clr_ovf      (clr_ovf),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .ovf          (ovf),
    .tickets_sent (tickets_sent)
  );

  nonce_reporter #(
    .NONCE_ADJ (28'd3),
    .MSB_FIRST (1'b1)
  ) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .got_ticket   (got2),
    .golden_nonce (nonce2),
    .start_mining (start2),
    .clr_ovf      (clr2),
    .tx_data      (data2),
    .tx_valid     (valid2),
    .tx_ready     (ready2),
    .busy         (busy2),
    .ovf          (ovf2),
    .tickets_sent (sent2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    got_ticket = 1'b0;
    golden_nonce = 32'd0;
    start_mining = 1'b0;
    clr_ovf = 1'b0;
    tx_ready = 1'b1;
    got2 = 1'b0;
    nonce2 = 32'd0;
    start2 = 1'b0;
    clr2 = 1'b0;
    ready2 = 1'b1;
    #12;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00
        || busy !== 1'b0 || ovf !== 1'b0
        || tickets_sent !== 16'd0) begin
      errors++;
      $display("FAIL reset v=%b d=%h b=%b o=%b n=%0d exp 0",
               tx_valid, tx_data, busy, ovf, tickets_sent);
    end
    checks++;
    if (valid2 !== 1'b0 || sent2 !== 16'd0) begin
      errors++;
      $display("FAIL reset2 v=%b n=%0d exp 0", valid2, sent2);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    step();
  endtask

  task automatic test_basic();
    logic [7:0] e [4];
    e = '{8'h05, 8'h01, 8'h00, 8'h30};
    golden_nonce = 32'h3000_0105;
    got_ticket = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== e[i]) begin
        errors++;
        $display("FAIL basic_b%0d v=%b d=%h exp v=1 d=%h",
                 i, tx_valid, tx_data, e[i]);
      end
    end
    step();
    checks++;
    if (tx_valid !== 1'b0 || tickets_sent !== 16'd1
        || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end v=%b n=%0d b=%b exp 0/1/0",
               tx_valid, tickets_sent, busy);
    end
    got_ticket = 1'b0;
    step();
  endtask

  task automatic test_adj_msb();
    logic [7:0] e [4];
    e = '{8'h5F, 8'hFF, 8'hFF, 8'hFE};
    nonce2 = 32'h5000_0001;
    got2 = 1'b1;
    ready2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (valid2 !== 1'b1 || data2 !== e[i]) begin
        errors++;
        $display("FAIL adj_b%0d v=%b d=%h exp v=1 d=%h",
                 i, valid2, data2, e[i]);
      end
    end
    step();
    checks++;
    if (valid2 !== 1'b0 || sent2 !== 16'd1) begin
      errors++;
      $display("FAIL adj_end v=%b n=%0d exp 0/1",
               valid2, sent2);
    end
    got2 = 1'b0;
    step();
  endtask

  task automatic test_stall();
    logic [7:0] e [4];
    int bad;
    e = '{8'h05, 8'h01, 8'h00, 8'h30};
    golden_nonce = 32'h3000_0105;
    tx_ready = 1'b0;
    got_ticket = 1'b1;
    step();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx_valid !== 1'b1 || tx_data !== 8'h05)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold bad_cycles=%0d exp 0 (v=%b d=%h)",
               bad, tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== e[i]) begin
        errors++;
        $display("FAIL stall_b%0d v=%b d=%h exp v=1 d=%h",
                 i, tx_valid, tx_data, e[i]);
      end
    end
    step();
    checks++;
    if (tx_valid !== 1'b0 || tickets_sent !== 16'd2) begin
      errors++;
      $display("FAIL stall_end v=%b n=%0d exp 0/2",
               tx_valid, tickets_sent);
    end
    got_ticket = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] e [8];
    e = '{8'h04, 8'h03, 8'h00, 8'h20,
          8'hAA, 8'h00, 8'h00, 8'h10};
    golden_nonce = 32'h2000_0304;
    got_ticket = 1'b1;
    tx_ready = 1'b1;
    step();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== e[0]) begin
      errors++;
      $display("FAIL b2b_b0 v=%b d=%h exp 1/%h",
               tx_valid, tx_data, e[0]);
    end
    start_mining = 1'b1;
    step();
    start_mining = 1'b0;
    golden_nonce = 32'h1000_00AA;
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== e[i]
          || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_b%0d v=%b d=%h b=%b exp 1/%h/1",
                 i, tx_valid, tx_data, busy, e[i]);
      end
      step();
    end
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0
        || tickets_sent !== 16'd4) begin
      errors++;
      $display("FAIL b2b_end v=%b b=%b n=%0d exp 0/0/4",
               tx_valid, busy, tickets_sent);
    end
    got_ticket = 1'b0;
    step();
  endtask

  task automatic test_ovf_and_reset();
    tx_ready = 1'b0;
    golden_nonce = 32'h4433_2211;
    got_ticket = 1'b1;
    step();
    start_mining = 1'b1;
    step();
    start_mining = 1'b0;
    golden_nonce = 32'h0000_0055;
    step();
    checks++;
    if (busy !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pend b=%b o=%b exp 1/0", busy, ovf);
    end
    start_mining = 1'b1;
    step();
    start_mining = 1'b0;
    golden_nonce = 32'h0000_0066;
    step();
    checks++;
    if (ovf !== 1'b1 || tx_data !== 8'h11) begin
      errors++;
      $display("FAIL ovf_set o=%b d=%h exp 1/11", ovf, tx_data);
    end
    start_mining = 1'b1;
    step();
    start_mining = 1'b0;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clr_drop o=%b exp 1", ovf);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr o=%b exp 0", ovf);
    end
    got_ticket = 1'b0;
    tx_ready = 1'b1;
    step();
    step();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h33
        || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre v=%b d=%h b=%b exp 1/33/1",
               tx_valid, tx_data, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0
        || tickets_sent !== 16'd0) begin
      errors++;
      $display("FAIL rst_async v=%b b=%b n=%0d exp 0/0/0",
               tx_valid, busy, tickets_sent);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (tx_valid !== 1'b0 || busy !== 1'b0)
          bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rst_quiet bad_cycles=%0d exp 0", bad);
      end
    end
    golden_nonce = 32'h0000_0077;
    got_ticket = 1'b1;
    step();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin
      errors++;
      $display("FAIL rst_new v=%b d=%h exp 1/77",
               tx_valid, tx_data);
    end
    got_ticket = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_adj_msb();
    test_stall();
    test_back_to_back();
    test_ovf_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nonce_reporter.md
Name: nonce_reporter

Overview:
- Sits directly downstream of the SHA-256 miner core.
- Watches the core's sticky got_ticket flag and captures golden_nonce on each new ticket.
- Corrects the 28-bit cycle count for pipeline latency.
- Serializes the 4-byte result onto a byte-wide valid/ready stream feeding the UART transmitter, with one-deep buffering so a ticket arriving mid-transmission is not lost.

Parameters:
- NONCE_ADJ, 28'd0: value subtracted (mod 2^28) from golden_nonce[27:0] before reporting; compensates core pipeline latency.
- MSB_FIRST, 1'b0: 0 = byte 0 is nonce[7:0] (little-endian on the wire); 1 = byte 0 is nonce[31:24].

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0); deassertion synchronous to clk is the integrator's responsibility.
- got_ticket  input  1  sticky ticket flag from miner core; synchronous to clk.
- golden_nonce  input  32  {nonce_start[3:0], count[27:0]}; valid whenever got_ticket=1.
- start_mining  input  1  new-job pulse (already synchronized to clk); re-arms edge detection.
- clr_ovf  input  1  single-cycle pulse; clears ovf.
- tx_data  output  8  byte to transmitter.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  transmitter accepts byte when tx_valid and tx_ready are both 1 in the same cycle.
- busy  output  1  1 while a nonce is being sent or is pending.
- ovf  output  1  sticky: a ticket was dropped because the send slot and the pending slot were both full.
- tickets_sent  output  16  count of fully transmitted nonces; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx_valid=0, tx_data=0, busy=0, ovf=0, tickets_sent=0, pending empty, got_ticket_q=0. Reset mid-transmission aborts the current and pending nonces; no further bytes are emitted.
- Edge detect:
  - got_ticket_q <= got_ticket every cycle.
  - A ticket event is got_ticket=1 and got_ticket_q=0.
  - start_mining forces got_ticket_q <= 0, so a flag that is still high is re-reported once per job.
- Nonce correction, registered at capture: adj = {golden_nonce[31:28], (golden_nonce[27:0] - NONCE_ADJ) mod 2^28}. The upper 4 bits are never altered and there is no borrow into bit 28.
- Buffering: one shift register (in flight) plus one pending register. On a ticket event:
  - if IDLE, load shift;
  - else if pending is empty, load pending;
  - else drop and set ovf=1.
- FSM states:
  - IDLE: tx_valid=0. A ticket event loads shift; the next cycle is SEND with byte index 0. First byte is valid 1 cycle after the event cycle.
  - SEND: tx_valid=1; tx_data = selected byte of shift per MSB_FIRST. Holds stable until tx_ready. On a handshake, index increments.
  - On the handshake of byte 3: tickets_sent increments. If pending is full (or a ticket event occurs in this same cycle), shift <= that nonce (pending takes priority over the simultaneous event; the event then goes to pending) and the FSM stays in SEND with index 0 and tx_valid staying 1 with no bubble. Otherwise the FSM goes to IDLE.
- tx_valid never drops in SEND without a handshake.
- busy = (state==SEND) | pending_full.
- ovf:
  - cleared by clr_ovf;
  - clr_ovf and a simultaneous drop in the same cycle leaves ovf=1;
  - start_mining does not clear ovf.
- Simultaneous start_mining and ticket event in one cycle: the event is still captured (start_mining only affects got_ticket_q for later cycles).

Test Plan:
- Reset, then got_ticket rises with golden_nonce=32'h3000_0105, NONCE_ADJ=0, MSB_FIRST=0, tx_ready=1 -> tx_valid high on cycles +1..+4 with bytes 05,01,00,30; then tx_valid=0; tickets_sent=1.
- NONCE_ADJ=28'd3, golden_nonce=32'h5000_0001 -> reported nonce 32'h5FFF_FFFE (low 28 bits wrap, top nibble unchanged). MSB_FIRST=1 -> bytes 5F,FF,FF,FE.
- tx_ready held 0 for 10 cycles after the first byte -> tx_valid stays 1 and tx_data stays 05 throughout; resumes on tx_ready=1.
- Ticket A, then start_mining, then ticket B (32'h1000_00AA) raised during A's byte 1 with tx_ready=1 -> B emitted back-to-back after A with no idle cycle; tickets_sent=2; busy falls after B's last byte.
- Three tickets (separated by start_mining pulses) during one stalled transmission -> third dropped, ovf=1; clr_ovf pulse -> ovf=0.
- rst driven 0 during byte 2 of a send with a pending nonce -> tx_valid=0 immediately (asynchronous); after release, no bytes are emitted until a new ticket event.
